// File: rtl/tick_timer_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tick_timer_bank_pkg
//  Description : Shared timebase constants, timer state encoding and the
//                ceil(log2) helper used by the timer bank and its prescaler.
//  Revision    : 1.0 - initial release
// ============================================================================
package tick_timer_bank_pkg;

    // Ceil(log2(value)), never less than 1 so a counter always has a bit.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Default system clock and timebase rates.
    localparam int C_CLK_HZ  = 100_000_000;
    localparam int C_TICK_HZ = 1000;

    // Clocks per timebase tick and the prescaler counter width it needs.
    localparam int C_DIV   = C_CLK_HZ / C_TICK_HZ;
    localparam int C_DIV_W = clog2(C_DIV);

    // Per-timer state: idle, or counting down ticks.
    typedef enum logic [0:0] {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_t;

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Free-running divide-by-DIV counter producing a one-cycle
//                timebase enable. Shared by every timebase consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler
    import tick_timer_bank_pkg::*;
#(
    parameter int DIV = C_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int c_cnt_w = clog2(DIV);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIV - 1);

    // A divider of 0 or 1 has no meaningful one-cycle pulse.
    generate
        if (DIV < 2) begin : g_bad_div
            $error("tick_prescaler: DIV must be at least 2");
        end
    endgenerate

    logic [c_cnt_w-1:0] r_cnt;

    // Count 0..DIV-1 and wrap; restarts from 0 whenever reset is applied.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Decoded straight from the register, so it is glitch-free and 0 in reset.
    assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/tick_timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tick_timer_bank
//  Description : N independent countdown timers on one shared prescaled
//                timebase, loaded through a round-robin arbitrated port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_timer_bank
    import tick_timer_bank_pkg::*;
#(
    parameter int CLK_HZ   = C_CLK_HZ,
    parameter int TICK_HZ  = C_TICK_HZ,
    parameter int N_TIMERS = 4,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_TIMERS-1:0]       start_req,
    input  logic [N_TIMERS*CNT_W-1:0] start_len,
    output logic [N_TIMERS-1:0]       start_ack,
    input  logic [N_TIMERS-1:0]       cancel,
    output logic [N_TIMERS-1:0]       busy,
    output logic [N_TIMERS-1:0]       expired,
    output logic                      tick
);

    localparam int c_div   = CLK_HZ / TICK_HZ;
    localparam int c_ptr_w = clog2(N_TIMERS);

    // The timebase must divide evenly and the bank size is bounded.
    generate
        if ((CLK_HZ % TICK_HZ) != 0 || c_div < 2) begin : g_bad_div
            $error("tick_timer_bank: CLK_HZ/TICK_HZ must be an integer >= 2");
        end
        if (N_TIMERS < 2 || N_TIMERS > 8) begin : g_bad_n
            $error("tick_timer_bank: N_TIMERS must be in 2..8");
        end
    endgenerate

    logic w_tick;

    tick_prescaler #(
        .DIV (c_div)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign tick = w_tick;

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic [c_ptr_w-1:0]  r_ptr;
    logic [c_ptr_w-1:0]  w_ptr_nxt;
    logic [N_TIMERS-1:0] r_ack;
    logic [N_TIMERS-1:0] w_elig;
    logic [N_TIMERS-1:0] w_grant;
    logic                w_found;
    int                  w_tgt;

    // An index whose ack is showing is still holding req; never regrant it.
    assign w_elig = start_req & ~r_ack;

    // Walk the indices starting at the pointer and grant the first eligible.
    always_comb begin
        w_grant   = '0;
        w_ptr_nxt = r_ptr;
        w_found   = 1'b0;
        w_tgt     = 0;
        for (int k = 0; k < N_TIMERS; k++) begin
            w_tgt = int'(r_ptr) + k;
            if (w_tgt >= N_TIMERS) begin
                w_tgt = w_tgt - N_TIMERS;
            end
            for (int i = 0; i < N_TIMERS; i++) begin
                if (!w_found && (i == w_tgt) && w_elig[i]) begin
                    w_found    = 1'b1;
                    w_grant[i] = 1'b1;
                    w_ptr_nxt  = (i == N_TIMERS - 1) ? '0 : c_ptr_w'(i + 1);
                end
            end
        end
    end

    // Pointer moves past the winner; ack is the registered grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
            r_ack <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
            r_ack <= w_grant;
        end
    end

    assign start_ack = r_ack;

    // ------------------------------------------------------------------
    // Timer array
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_TIMERS; gi++) begin : g_timer
            tmr_state_t       r_state;
            tmr_state_t       w_state_nxt;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_nxt;
            logic [CNT_W-1:0] w_len;
            logic             r_exp;
            logic             w_exp_nxt;

            assign w_len = start_len[gi*CNT_W +: CNT_W];

            // Load beats cancel beats tick; a zero length is loaded as one.
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                w_exp_nxt   = 1'b0;
                if (w_grant[gi]) begin
                    w_state_nxt = TMR_RUN;
                    w_cnt_nxt   = (w_len == '0) ? CNT_W'(1) : w_len;
                end else if (cancel[gi]) begin
                    w_state_nxt = TMR_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_tick && (r_state == TMR_RUN)) begin
                    if (r_cnt <= CNT_W'(1)) begin
                        w_state_nxt = TMR_IDLE;
                        w_cnt_nxt   = '0;
                        w_exp_nxt   = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end

            // Timer state, count and expiry pulse registers.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_state <= TMR_IDLE;
                    r_cnt   <= '0;
                    r_exp   <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_exp   <= w_exp_nxt;
                end
            end

            assign busy[gi]    = (r_state == TMR_RUN);
            assign expired[gi] = r_exp;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tick_timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tick_timer_bank
//  Description : Self-checking bench for tick_timer_bank at DIV=10. Expected
//                ack/expiry/clear events are queued when stimulus is driven
//                and compared against the outputs every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_timer_bank;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int DIV = 10;

    localparam int K_ACK = 0;
    localparam int K_EXP = 1;
    localparam int K_CLR = 2;

    typedef struct {
        int cyc;
        int kind;
        int idx;
    } sb_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   start_req = '0;
    logic [N*W-1:0] start_len = '0;
    logic [N-1:0]   start_ack;
    logic [N-1:0]   cancel = '0;
    logic [N-1:0]   busy;
    logic [N-1:0]   expired;
    logic           tick;

    sb_t          sb_q[$];
    logic [N-1:0] exp_busy = '0;
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_mis = 0;

    tick_timer_bank #(
        .CLK_HZ   (1000),
        .TICK_HZ  (100),
        .N_TIMERS (N),
        .CNT_W    (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_req (start_req),
        .start_len (start_len),
        .start_ack (start_ack),
        .cancel    (cancel),
        .busy      (busy),
        .expired   (expired),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; the DUT prescaler count tracks it mod DIV.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Edge at which a timer loaded at edge g with length len expires.
    function automatic int expiry_edge(input int g, input int len);
        int l;
        l = (len == 0) ? 1 : len;
        return (g / DIV + 1) * DIV + (l - 1) * DIV;
    endfunction

    // Drop pending expiry/clear events of idx at or after edge c.
    task automatic sb_purge(input int idx, input int c);
        sb_t nq[$];
        foreach (sb_q[j]) begin
            if (!(sb_q[j].idx == idx && sb_q[j].kind != K_ACK && sb_q[j].cyc >= c))
                nq.push_back(sb_q[j]);
        end
        sb_q = nq;
    endtask

    task automatic sb_load(input int idx, input int g, input int len);
        sb_t e;
        sb_purge(idx, g);
        e.idx = idx;
        e.cyc = g;                    e.kind = K_ACK; sb_q.push_back(e);
        e.cyc = expiry_edge(g, len);  e.kind = K_EXP; sb_q.push_back(e);
    endtask

    task automatic sb_cancel(input int idx, input int c);
        sb_t e;
        sb_purge(idx, c);
        e.idx = idx; e.cyc = c; e.kind = K_CLR;
        sb_q.push_back(e);
    endtask

    // Pop this cycle's expected events and compare all outputs.
    task automatic monitor();
        logic [N-1:0] e_ack;
        logic [N-1:0] e_exp;
        sb_t          keep[$];
        e_ack = '0;
        e_exp = '0;
        foreach (sb_q[j]) begin
            if (sb_q[j].cyc == cyc) begin
                case (sb_q[j].kind)
                    K_ACK:   begin e_ack[sb_q[j].idx] = 1'b1; exp_busy[sb_q[j].idx] = 1'b1; end
                    K_EXP:   begin e_exp[sb_q[j].idx] = 1'b1; exp_busy[sb_q[j].idx] = 1'b0; end
                    default: exp_busy[sb_q[j].idx] = 1'b0;
                endcase
            end else begin
                keep.push_back(sb_q[j]);
            end
        end
        sb_q = keep;
        check("tick",    32'(tick),      32'((rst && (cyc % DIV == DIV - 1)) ? 1 : 0));
        check("ack",     32'(start_ack), 32'(e_ack));
        check("expired", 32'(expired),   32'(e_exp));
        check("busy",    32'(busy),      32'(exp_busy));
    endtask

    // One clock: sample at negedge, then act as requesters after the rising edge.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #2;
        cancel = '0;
        for (int i = 0; i < N; i++) begin
            if (start_ack[i]) start_req[i] = 1'b0;
        end
    endtask

    task automatic set_len(input int idx, input int len);
        start_len[idx*W +: W] = W'(len);
    endtask

    // Uncontended request: granted on the next edge.
    task automatic req_timer(input int idx, input int len);
        set_len(idx, len);
        start_req[idx] = 1'b1;
        sb_load(idx, cyc + 1, len);
    endtask

    initial begin
        int c;
        int g;
        int first;

        repeat (3) step();
        check("rst_ack",     32'(start_ack), 32'd0);
        check("rst_busy",    32'(busy),      32'd0);
        check("rst_expired", 32'(expired),   32'd0);
        check("rst_tick",    32'(tick),      32'd0);
        #1 rst = 1'b1;

        // Timebase alone.
        repeat (32) step();

        // All four together, then re-raise while running, then only 2 and 3.
        for (int i = 0; i < N; i++) set_len(i, 2 + i);
        start_req = '1;
        c = cyc;
        for (int i = 0; i < N; i++) sb_load(i, c + 1 + i, 2 + i);
        repeat (6) step();
        for (int i = 0; i < N; i++) set_len(i, 6 + i);
        start_req = '1;
        c = cyc;
        for (int i = 0; i < N; i++) sb_load(i, c + 1 + i, 6 + i);
        repeat (6) step();
        set_len(2, 1);
        set_len(3, 1);
        start_req[2] = 1'b1;
        start_req[3] = 1'b1;
        c = cyc;
        sb_load(2, c + 1, 1);
        sb_load(3, c + 2, 1);
        repeat (110) step();

        // Single load of length 3.
        req_timer(0, 3);
        repeat (45) step();

        // Cancel after two ticks, cancel while idle, cancel together with req.
        req_timer(1, 5);
        g = cyc + 1;
        first = (g / DIV + 1) * DIV;
        while (cyc < first + DIV) step();
        cancel[1] = 1'b1;
        sb_cancel(1, cyc + 1);
        step();
        repeat (5) step();
        cancel[3] = 1'b1;
        sb_cancel(3, cyc + 1);
        step();
        req_timer(1, 5);
        repeat (12) step();
        cancel[1] = 1'b1;
        req_timer(1, 4);
        step();
        repeat (60) step();

        // Load on a tick edge, then a zero-length load.
        while (cyc % DIV != DIV - 1) step();
        req_timer(0, 2);
        repeat (3) step();
        req_timer(3, 0);
        repeat (35) step();

        // Reset mid-count with requests for 0 and 2 held across it.
        req_timer(0, 4);
        step();
        req_timer(2, 4);
        step();
        req_timer(1, 4);
        step();
        repeat (12) step();
        #1 rst = 1'b0;
        set_len(0, 3);
        set_len(2, 3);
        start_req = 4'b0101;
        #1;
        check("arst_ack",     32'(start_ack), 32'd0);
        check("arst_busy",    32'(busy),      32'd0);
        check("arst_expired", 32'(expired),   32'd0);
        check("arst_tick",    32'(tick),      32'd0);
        sb_q.delete();
        exp_busy = '0;
        repeat (2) step();
        #1 rst = 1'b1;
        sb_load(0, 1, 3);
        sb_load(2, 2, 3);
        repeat (50) step();

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        check("end_busy", 32'(busy),        32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tick_timer_bank.md
# tick_timer_bank

Bank of N_TIMERS independent millisecond countdown timers sharing one prescaled 1 kHz timebase derived from the 100 MHz system clock. Requesters start timers through a single shared load port, arbitrated round-robin with a req/ack handshake. The block also exports the timebase as a one-cycle enable pulse. It replaces per-consumer divided clocks with one scheduled, single-clock-domain resource.

## Interface
- CLK_HZ, 100_000_000, system clock frequency
- TICK_HZ, 1000, timebase rate
- N_TIMERS, 4, number of timers/requesters (2..8)
- CNT_W, 16, timer length width, in ticks
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start_req  in  N_TIMERS  per-timer load request, level, held until ack
- start_len  in  N_TIMERS*CNT_W  per-timer length; slice i = [i*CNT_W +: CNT_W], stable while req high
- start_ack  out  N_TIMERS  one-cycle grant pulse, registered
- cancel  in  N_TIMERS  one-cycle pulse, stops timer i without expiry
- busy  out  N_TIMERS  timer i counting
- expired  out  N_TIMERS  one-cycle pulse when timer i reaches zero
- tick  out  1  one-cycle timebase pulse every DIV = CLK_HZ/TICK_HZ clocks

## Operation
- Prescaler: counter of width clog2(DIV) counts 0..DIV-1 and wraps. tick is high while the count equals DIV-1. DIV must be an integer ≥ 2; elaboration fails otherwise.
- Arbiter: each cycle, grants at most one requester with start_req high and start_ack low. Search order is round-robin starting at the index after the last grant (pointer resets to 0, so index 0 has first priority). The grant loads start_len[i] into timer i, sets busy[i], and pulses start_ack[i] on the next cycle.
- Timer state per index: IDLE (busy=0) or RUN (busy=1).
  - IDLE→RUN on grant.
  - RUN: decrement on each tick.
  - RUN→IDLE when a tick occurs with count = 1; expired[i] pulses in the same registered update as busy falling.
- Length 0 behaves as length 1: expires on the first tick after load.
- Restart while RUN: a grant reloads the count with no expiry pulse, and the timer stays RUN.
- Priority per timer in one cycle: grant > cancel > tick decrement. A grant together with a cancel means the timer is loaded. Load and tick in the same cycle load without decrementing.
- Cancel while IDLE: no effect.
- Reset values: prescaler 0, rr pointer 0, all counts 0, busy 0, expired 0, start_ack 0, tick 0.
- Reset mid-operation clears all timers immediately. No expired pulses are issued, and pending requests are re-arbitrated from index 0 after reset release.

## Timing
- Grant latency: req sampled high at edge k → start_ack and busy high after edge k+1.
- Requesters drop req the cycle after seeing ack. The arbiter masks any index whose ack is currently high, so there is no double grant.
- Worst-case grant wait is N_TIMERS-1 cycles with all requests pending.
- Timer with length L ≥ 1 expires on the L-th tick strictly after its load edge. Expiry occurs between (L-1)*DIV+1 and L*DIV cycles after ack.
- expired is asserted for exactly 1 clock, coincident with busy falling. Timers expiring on the same tick pulse simultaneously.
- tick period is exactly DIV clocks. The first tick occurs DIV clocks after reset release.

## Structure
- The shared package holds:
  - the localparam DIV and its derived width
  - the timer state enum (IDLE, RUN)
  - the clog2 helper
- Sub-module tick_prescaler (clk, rst, tick) is reused by other timebase consumers. The arbiter and timer array stay in the top level.

## Test plan
- CLK_HZ=1000, TICK_HZ=100 (DIV=10): after reset release, tick pulses at cycles 10, 20, 30, each 1 clock wide.
- req[0] with len=3 → ack[0] 1 cycle later. expired[0] pulses on the 3rd tick after load, and busy[0] is high for exactly the span between ack and that pulse.
- All 4 reqs raised together with distinct lengths → acks at consecutive cycles in order 0,1,2,3. Then re-raise all → next order starts at 0 (pointer after 3); a second round with only req[2],[3] pending grants 2 then 3.
- Timer 1 running (len=5): cancel[1] after 2 ticks → busy[1] falls and expired[1] never pulses. Cancel and req in the same cycle → timer reloads.
- Load issued exactly on a tick cycle with len=2 → that tick is not counted, and expiry occurs on the 2nd following tick. len=0 → expiry on the 1st tick.
- rst asserted asynchronously mid-count with timers 0–2 busy → all outputs 0 immediately, no expired pulses; after release, the prescaler restarts and the first tick arrives 10 cycles later.
